// File: rtl/id_ex_pkg.sv
// id_ex_pkg
//   Shared types and constants for the ID/EX issue register slice.
//   - ctrl_t / CTRL_*_OFS : layout of the opaque 24-bit control bundle that
//     travels from the main decoder to the execute stage.
//   - BUBBLE_CTRL         : control bundle of a bubble (all zeros = no-op).
//   - sb_entry_t          : one load-use scoreboard entry {vld, rd}.
//   - LOAD_LAT_MAX        : largest supported load latency.
//   - make_entry()        : builds a scoreboard entry from slot contents.
package id_ex_pkg;

  localparam int LOAD_LAT_MAX = 4;

  // Scoreboard entries hold register labels up to this width; narrower
  // labels are zero-extended before comparison.
  localparam int RA_W_MAX = 8;

  // Bit offsets (LSB) of each field within the control bundle.
  localparam int CTRL_STORE_OFS  = 0;
  localparam int CTRL_JUMP_OFS   = 1;
  localparam int CTRL_BRANCH_OFS = 2;
  localparam int CTRL_EX_OP_OFS  = 3;
  localparam int CTRL_FUNCT7_OFS = 5;
  localparam int CTRL_FUNCT5_OFS = 12;
  localparam int CTRL_FUNCT3_OFS = 17;
  localparam int CTRL_WB_SEL_OFS = 20;
  localparam int CTRL_OP_SEL_OFS = 22;
  localparam int CTRL_W_DEF      = 24;

  typedef struct packed {
    logic [1:0] op_sel;
    logic [1:0] wb_sel;
    logic [2:0] funct3;
    logic [4:0] funct5;
    logic [6:0] funct7;
    logic [1:0] ex_op;
    logic       branch;
    logic       jump;
    logic       store;
  } ctrl_t;

  localparam ctrl_t BUBBLE_CTRL = '0;

  typedef struct packed {
    logic                vld;
    logic [RA_W_MAX-1:0] rd;
  } sb_entry_t;

  // Only a real load that writes a non-zero register can create a hazard,
  // so x0 and non-writing loads never mark the entry valid.
  function automatic sb_entry_t make_entry(input logic                valid,
                                           input logic                is_load,
                                           input logic                rd_wen,
                                           input logic [RA_W_MAX-1:0] rd);
    sb_entry_t e;
    e.vld = valid & is_load & rd_wen & (rd != '0);
    e.rd  = rd;
    return e;
  endfunction

endpackage

// File: rtl/id_ex_issue_reg_load_use_scoreboard.sv
// load_use_scoreboard
//   Tracks loads that have left the EX slot but whose data is still not
//   available, and flags a hazard when the instruction in decode reads one
//   of them (or the load currently sitting in the EX slot).
//   Ports:
//     clk_i, rst_i        clock, async active-high reset
//     shift_i             advance the shift register one stage
//     shift_in_i          entry entering sb[0] on a shift
//     ex_entry_i          entry describing the current EX slot
//     src_valid_i         decode-side instruction present
//     rs1/rs2_label_i     source labels, rs1/rs2_used_i source actually read
//     hazard_o            load-use hazard against any entry in the window
module load_use_scoreboard
  import id_ex_pkg::*;
#(
  parameter int RA_W     = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            shift_i,
  input  sb_entry_t       shift_in_i,
  input  sb_entry_t       ex_entry_i,
  input  logic            src_valid_i,
  input  logic [RA_W-1:0] rs1_label_i,
  input  logic [RA_W-1:0] rs2_label_i,
  input  logic            rs1_used_i,
  input  logic            rs2_used_i,
  output logic            hazard_o
);

  // window[0] is the EX slot, window[k+1] is sb[k].
  sb_entry_t window [LOAD_LAT];

  logic [RA_W_MAX-1:0] rs1_ext;
  logic [RA_W_MAX-1:0] rs2_ext;
  logic                hit;

  assign window[0] = ex_entry_i;
  assign rs1_ext   = RA_W_MAX'(rs1_label_i);
  assign rs2_ext   = RA_W_MAX'(rs2_label_i);

  generate
    if (LOAD_LAT > 1) begin : g_sb
      sb_entry_t sb [LOAD_LAT-1];

      // Shift register of in-flight loads; frozen whenever the pipe does
      // not advance so a stall never lets a load age out early.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          sb <= '{default: '0};
        end else if (shift_i) begin
          sb[0] <= shift_in_i;
          for (int k = 1; k < LOAD_LAT - 1; k++) begin
            sb[k] <= sb[k-1];
          end
        end
      end

      for (genvar k = 0; k < LOAD_LAT - 1; k++) begin : g_win
        assign window[k+1] = sb[k];
      end
    end else begin : g_no_sb
      logic unused_sb;
      assign unused_sb = ^{clk_i, rst_i, shift_i, shift_in_i};
    end
  endgenerate

  // Compare both used sources against every valid entry in the window.
  always_comb begin
    hit = 1'b0;
    for (int k = 0; k < LOAD_LAT; k++) begin
      if (window[k].vld &&
          ((rs1_used_i && (rs1_ext == window[k].rd)) ||
           (rs2_used_i && (rs2_ext == window[k].rd)))) begin
        hit = 1'b1;
      end
    end
  end

  assign hazard_o = src_valid_i & hit;

endmodule

// File: rtl/id_ex_issue_reg.sv
// id_ex_issue_reg
//   ID/EX pipeline register with an in-place load-use scoreboard. Captures a
//   decoded instruction when execute can advance and no load-use hazard is
//   present; otherwise inserts a bubble or holds.
//   Edge priority: reset > flush > hold (no advance) > capture > bubble.
//   Ports:
//     clk_i, rst_i            clock, async active-high reset
//     flush_i, busywait_i     kill EX slot / memory stall (freeze)
//     in_valid_i, in_ready_o  decode-side handshake
//     in_*                    decoded instruction fields
//     out_valid_o, out_ready_i execute-side handshake
//     out_*                   registered instruction fields
//     load_stall_o            load-use hazard this cycle
//     stall_cnt_o, bubble_cnt_o performance counters
//   Optional: define ID_EX_PERF_CNT_EN to build saturating counters;
//   otherwise both counter ports read 0.
module id_ex_issue_reg
  import id_ex_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int PC_W     = 30,
  parameter int RA_W     = 5,
  parameter int CTRL_W   = 24,
  parameter int LOAD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              busywait_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [PC_W-1:0]   in_pc_i,
  input  logic [RA_W-1:0]   in_rs1_label_i,
  input  logic [RA_W-1:0]   in_rs2_label_i,
  input  logic [RA_W-1:0]   in_rd_label_i,
  input  logic              in_rs1_used_i,
  input  logic              in_rs2_used_i,
  input  logic              in_rd_wen_i,
  input  logic              in_is_load_i,
  input  logic [XLEN-1:0]   in_rs1_value_i,
  input  logic [XLEN-1:0]   in_rs2_value_i,
  input  logic [XLEN-1:0]   in_imm_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [PC_W-1:0]   out_pc_o,
  output logic [RA_W-1:0]   out_rs1_label_o,
  output logic [RA_W-1:0]   out_rs2_label_o,
  output logic [RA_W-1:0]   out_rd_label_o,
  output logic              out_rd_wen_o,
  output logic              out_is_load_o,
  output logic [XLEN-1:0]   out_rs1_value_o,
  output logic [XLEN-1:0]   out_rs2_value_o,
  output logic [XLEN-1:0]   out_imm_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic              load_stall_o,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       bubble_cnt_o
);

  typedef struct packed {
    logic              valid;
    logic [PC_W-1:0]   pc;
    logic [RA_W-1:0]   rs1;
    logic [RA_W-1:0]   rs2;
    logic [RA_W-1:0]   rd;
    logic              rd_wen;
    logic              is_load;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic [XLEN-1:0]   imm;
    logic [CTRL_W-1:0] ctrl;
  } slot_t;

  slot_t     slot_q;
  slot_t     slot_in;
  slot_t     bubble;
  logic      adv;
  logic      hazard;
  logic      capture;
  sb_entry_t ex_entry;
  sb_entry_t sb_shift_in;

  assign adv     = out_ready_i & ~busywait_i;
  assign capture = in_valid_i & adv & ~hazard & ~flush_i;

  // A flushed slot is killed, so its load must not enter the scoreboard.
  assign ex_entry    = make_entry(slot_q.valid, slot_q.is_load, slot_q.rd_wen,
                                  RA_W_MAX'(slot_q.rd));
  assign sb_shift_in = flush_i ? '0 : ex_entry;

  load_use_scoreboard #(
    .RA_W     (RA_W),
    .LOAD_LAT (LOAD_LAT)
  ) u_sb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .shift_i     (adv),
    .shift_in_i  (sb_shift_in),
    .ex_entry_i  (ex_entry),
    .src_valid_i (in_valid_i),
    .rs1_label_i (in_rs1_label_i),
    .rs2_label_i (in_rs2_label_i),
    .rs1_used_i  (in_rs1_used_i),
    .rs2_used_i  (in_rs2_used_i),
    .hazard_o    (hazard)
  );

  assign load_stall_o = hazard;
  assign in_ready_o   = adv & ~hazard & ~flush_i;

  // A bubble is an all-zero slot carrying the no-op control bundle.
  always_comb begin
    bubble      = '0;
    bubble.ctrl = CTRL_W'(BUBBLE_CTRL);
  end

  assign slot_in = '{valid:   1'b1,
                     pc:      in_pc_i,
                     rs1:     in_rs1_label_i,
                     rs2:     in_rs2_label_i,
                     rd:      in_rd_label_i,
                     rd_wen:  in_rd_wen_i,
                     is_load: in_is_load_i,
                     rs1_val: in_rs1_value_i,
                     rs2_val: in_rs2_value_i,
                     imm:     in_imm_i,
                     ctrl:    in_ctrl_i};

  // EX slot: flush beats busywait, then a stalled pipe holds, otherwise
  // either the decoded instruction or a bubble is loaded.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_q <= '0;
    end else if (flush_i) begin
      slot_q <= bubble;
    end else if (adv) begin
      slot_q <= capture ? slot_in : bubble;
    end
  end

  assign out_valid_o     = slot_q.valid;
  assign out_pc_o        = slot_q.pc;
  assign out_rs1_label_o = slot_q.rs1;
  assign out_rs2_label_o = slot_q.rs2;
  assign out_rd_label_o  = slot_q.rd;
  assign out_rd_wen_o    = slot_q.rd_wen;
  assign out_is_load_o   = slot_q.is_load;
  assign out_rs1_value_o = slot_q.rs1_val;
  assign out_rs2_value_o = slot_q.rs2_val;
  assign out_imm_o       = slot_q.imm;
  assign out_ctrl_o      = slot_q.ctrl;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_cnt_q;
  logic [31:0] bubble_cnt_q;
  logic        stall_evt;
  logic        bubble_evt;

  // A flushed cycle is not a stall even if a hazard is also present.
  assign stall_evt  = hazard & adv & ~flush_i;
  assign bubble_evt = flush_i | (adv & ~capture);

  // Saturating event counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (stall_evt && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
      if (bubble_evt && (bubble_cnt_q != '1)) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`else
  assign stall_cnt_o  = '0;
  assign bubble_cnt_o = '0;
`endif

endmodule

// File: tb/tb_id_ex_issue_reg.sv
// tb_id_ex_issue_reg
//   Directed bench for id_ex_issue_reg. Two instances share one input bus:
//   dut_a uses LOAD_LAT=1, dut_b uses LOAD_LAT=3. Issued instructions are
//   queued when driven and compared when the selected instance hands them
//   to execute. Counter expectations follow ID_EX_PERF_CNT_EN.
module tb_id_ex_issue_reg;

`ifdef ID_EX_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct {
    logic [29:0] pc;
    logic [4:0]  rd;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;
  bit   mon_sel = 0;

  logic        clk = 0;
  logic        rst;
  logic        flush, busywait, in_valid, out_ready;
  logic [29:0] in_pc;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic        in_rs1_used, in_rs2_used, in_rd_wen, in_is_load;
  logic [31:0] in_rs1_val, in_rs2_val, in_imm;
  logic [23:0] in_ctrl;

  logic        a_in_ready, a_out_valid, a_rd_wen, a_is_load, a_stall;
  logic [29:0] a_pc;
  logic [4:0]  a_rs1, a_rs2, a_rd;
  logic [31:0] a_rs1_val, a_rs2_val, a_imm, a_stall_cnt, a_bubble_cnt;
  logic [23:0] a_ctrl;

  logic        b_in_ready, b_out_valid, b_rd_wen, b_is_load, b_stall;
  logic [29:0] b_pc;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic [31:0] b_rs1_val, b_rs2_val, b_imm, b_stall_cnt, b_bubble_cnt;
  logic [23:0] b_ctrl;

  always #5 clk = ~clk;

  id_ex_issue_reg #(.LOAD_LAT(1)) dut_a (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .busywait_i(busywait),
    .in_valid_i(in_valid), .in_ready_o(a_in_ready), .in_pc_i(in_pc),
    .in_rs1_label_i(in_rs1), .in_rs2_label_i(in_rs2), .in_rd_label_i(in_rd),
    .in_rs1_used_i(in_rs1_used), .in_rs2_used_i(in_rs2_used),
    .in_rd_wen_i(in_rd_wen), .in_is_load_i(in_is_load),
    .in_rs1_value_i(in_rs1_val), .in_rs2_value_i(in_rs2_val),
    .in_imm_i(in_imm), .in_ctrl_i(in_ctrl),
    .out_valid_o(a_out_valid), .out_ready_i(out_ready), .out_pc_o(a_pc),
    .out_rs1_label_o(a_rs1), .out_rs2_label_o(a_rs2), .out_rd_label_o(a_rd),
    .out_rd_wen_o(a_rd_wen), .out_is_load_o(a_is_load),
    .out_rs1_value_o(a_rs1_val), .out_rs2_value_o(a_rs2_val),
    .out_imm_o(a_imm), .out_ctrl_o(a_ctrl), .load_stall_o(a_stall),
    .stall_cnt_o(a_stall_cnt), .bubble_cnt_o(a_bubble_cnt)
  );

  id_ex_issue_reg #(.LOAD_LAT(3)) dut_b (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .busywait_i(busywait),
    .in_valid_i(in_valid), .in_ready_o(b_in_ready), .in_pc_i(in_pc),
    .in_rs1_label_i(in_rs1), .in_rs2_label_i(in_rs2), .in_rd_label_i(in_rd),
    .in_rs1_used_i(in_rs1_used), .in_rs2_used_i(in_rs2_used),
    .in_rd_wen_i(in_rd_wen), .in_is_load_i(in_is_load),
    .in_rs1_value_i(in_rs1_val), .in_rs2_value_i(in_rs2_val),
    .in_imm_i(in_imm), .in_ctrl_i(in_ctrl),
    .out_valid_o(b_out_valid), .out_ready_i(out_ready), .out_pc_o(b_pc),
    .out_rs1_label_o(b_rs1), .out_rs2_label_o(b_rs2), .out_rd_label_o(b_rd),
    .out_rd_wen_o(b_rd_wen), .out_is_load_o(b_is_load),
    .out_rs1_value_o(b_rs1_val), .out_rs2_value_o(b_rs2_val),
    .out_imm_o(b_imm), .out_ctrl_o(b_ctrl), .load_stall_o(b_stall),
    .stall_cnt_o(b_stall_cnt), .bubble_cnt_o(b_bubble_cnt)
  );

  function automatic logic [31:0] f_rs1_val(input logic [29:0] pc);
    return {pc, 2'b01};
  endfunction

  function automatic logic [23:0] f_ctrl(input logic [29:0] pc, input logic [4:0] rd);
    return {pc[15:0], rd, 3'b101};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one decoded instruction; operand and control fields are derived
  // from pc/rd so the monitor can recompute them. push queues it as issued.
  task automatic applyStimulus(input logic v, input logic [29:0] pc,
                               input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic u1,
                               input logic u2, input logic wen,
                               input logic ld, input bit push);
    exp_t e;
    in_valid    = v;
    in_pc       = pc;
    in_rd       = rd;
    in_rs1      = rs1;
    in_rs2      = rs2;
    in_rs1_used = u1;
    in_rs2_used = u2;
    in_rd_wen   = wen;
    in_is_load  = ld;
    in_rs1_val  = f_rs1_val(pc);
    in_rs2_val  = ~f_rs1_val(pc);
    in_imm      = 32'(pc) * 5;
    in_ctrl     = f_ctrl(pc, rd);
    if (push) begin
      e.pc = pc;
      e.rd = rd;
      exp_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: whenever execute consumes the selected instance's
  // slot, the oldest queued instruction must be the one presented.
  always @(negedge clk) begin
    if (mon_en && !rst && out_ready && !busywait && !flush &&
        (mon_sel ? b_out_valid : a_out_valid)) begin
      if (exp_q.size() == 0) begin
        checkOutput("sb_unexpected_issue", 32'(mon_sel ? b_pc : a_pc), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("sb_pc", 32'(mon_sel ? b_pc : a_pc), 32'(e.pc));
        checkOutput("sb_rd", 32'(mon_sel ? b_rd : a_rd), 32'(e.rd));
        checkOutput("sb_rs1_val", mon_sel ? b_rs1_val : a_rs1_val, f_rs1_val(e.pc));
        checkOutput("sb_imm", mon_sel ? b_imm : a_imm, 32'(e.pc) * 5);
        checkOutput("sb_ctrl", 32'(mon_sel ? b_ctrl : a_ctrl), 32'(f_ctrl(e.pc, e.rd)));
      end
    end
  end

  initial begin
    rst = 1; flush = 0; busywait = 0; out_ready = 0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("rst_a_valid", 32'(a_out_valid), 0);
    checkOutput("rst_b_valid", 32'(b_out_valid), 0);
    checkOutput("rst_b_pc", 32'(b_pc), 0);
    checkOutput("rst_b_ctrl", 32'(b_ctrl), 0);
    checkOutput("rst_b_stall_cnt", b_stall_cnt, 0);
    checkOutput("rst_b_bubble_cnt", b_bubble_cnt, 0);
    checkOutput("rst_b_in_ready", 32'(b_in_ready), 0);
    tick();
    rst = 0;
    tick();

    // LOAD_LAT=1: lw x5; add x6,x5,x7 -> one bubble.
    $display("[TB] LOAD_LAT=1 load-use");
    mon_sel = 0; mon_en = 1; out_ready = 1;
    applyStimulus(1, 30'h10, 5, 1, 0, 1, 0, 1, 1, 1);
    #1;
    checkOutput("l1_lw_stall", 32'(a_stall), 0);
    checkOutput("l1_lw_ready", 32'(a_in_ready), 1);
    tick();
    applyStimulus(1, 30'h11, 6, 5, 7, 1, 1, 1, 0, 1);
    #1;
    checkOutput("l1_lw_valid", 32'(a_out_valid), 1);
    checkOutput("l1_add_stall", 32'(a_stall), 1);
    checkOutput("l1_add_ready", 32'(a_in_ready), 0);
    tick(); #1;
    checkOutput("l1_bubble_valid", 32'(a_out_valid), 0);
    checkOutput("l1_stall_clear", 32'(a_stall), 0);
    checkOutput("l1_ready_again", 32'(a_in_ready), 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("l1_add_valid", 32'(a_out_valid), 1);
    checkOutput("l1_add_rd", 32'(a_rd), 6);
    @(negedge clk);
    #1;
    rst = 1;
    #1;
    checkOutput("async_rst_a_valid", 32'(a_out_valid), 0);
    checkOutput("async_rst_a_rd", 32'(a_rd), 0);
    mon_en = 0; out_ready = 0;
    tick();
    rst = 0;
    tick();

    // LOAD_LAT=3: lw x5; add x6,x5,x1 -> three bubbles.
    $display("[TB] LOAD_LAT=3 load-use");
    mon_sel = 1; mon_en = 1; out_ready = 1;
    applyStimulus(1, 30'h20, 5, 2, 0, 1, 0, 1, 1, 1);
    #1;
    checkOutput("l3_lw_ready", 32'(b_in_ready), 1);
    tick();
    applyStimulus(1, 30'h21, 6, 5, 1, 1, 1, 1, 0, 1);
    #1;
    checkOutput("l3_lw_valid", 32'(b_out_valid), 1);
    checkOutput("l3_stall_0", 32'(b_stall), 1);
    checkOutput("l3_ready_0", 32'(b_in_ready), 0);
    for (int i = 1; i <= 2; i++) begin
      tick(); #1;
      checkOutput($sformatf("l3_bubble_%0d", i), 32'(b_out_valid), 0);
      checkOutput($sformatf("l3_stall_%0d", i), 32'(b_stall), 1);
    end
    tick(); #1;
    checkOutput("l3_bubble_3", 32'(b_out_valid), 0);
    checkOutput("l3_stall_end", 32'(b_stall), 0);
    checkOutput("l3_ready_end", 32'(b_in_ready), 1);
    tick();
    applyStimulus(1, 30'h22, 8, 3, 0, 1, 0, 1, 1, 1);
    #1;
    checkOutput("l3_add_valid", 32'(b_out_valid), 1);
    checkOutput("l3_add_rd", 32'(b_rd), 6);
    tick();

    // Flush together with busywait while lw x8 sits in the EX slot.
    $display("[TB] flush with busywait");
    exp_q.delete(0);
    flush = 1; busywait = 1;
    applyStimulus(1, 30'h23, 11, 8, 0, 1, 0, 1, 0, 1);
    #1;
    checkOutput("fl_stall", 32'(b_stall), 1);
    checkOutput("fl_ready", 32'(b_in_ready), 0);
    tick();
    flush = 0; busywait = 0;
    #1;
    checkOutput("fl_valid", 32'(b_out_valid), 0);
    checkOutput("fl_ctrl", 32'(b_ctrl), 0);
    checkOutput("fl_pc", 32'(b_pc), 0);
    checkOutput("fl_dep_stall", 32'(b_stall), 0);
    checkOutput("fl_dep_ready", 32'(b_in_ready), 1);
    checkOutput("cnt_stall_3", b_stall_cnt, PERF ? 3 : 0);
    checkOutput("cnt_bubble_4", b_bubble_cnt, PERF ? 4 : 0);
    tick();

    // lw x0 followed by a reader of x0 never stalls.
    applyStimulus(1, 30'h24, 0, 3, 0, 1, 0, 1, 1, 1);
    #1;
    checkOutput("x0_prev_rd", 32'(b_rd), 11);
    tick();
    applyStimulus(1, 30'h25, 12, 0, 0, 1, 1, 1, 0, 1);
    #1;
    checkOutput("x0_stall", 32'(b_stall), 0);
    checkOutput("x0_ready", 32'(b_in_ready), 1);
    tick();

    // lw x5 then lui x9 whose unused rs1 field is 5.
    applyStimulus(1, 30'h26, 5, 2, 0, 1, 0, 1, 1, 1);
    tick();
    applyStimulus(1, 30'h27, 9, 5, 5, 0, 0, 1, 0, 1);
    #1;
    checkOutput("lui_stall", 32'(b_stall), 0);
    checkOutput("lui_ready", 32'(b_in_ready), 1);
    tick();

    // Busywait for four cycles with a pending hazard.
    $display("[TB] busywait freeze");
    busywait = 1;
    applyStimulus(1, 30'h28, 13, 5, 2, 1, 1, 1, 0, 1);
    #1;
    checkOutput("bw_lui_valid", 32'(b_out_valid), 1);
    checkOutput("bw_lui_rd", 32'(b_rd), 9);
    checkOutput("bw_stall", 32'(b_stall), 1);
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      checkOutput($sformatf("bw_hold_valid_%0d", i), 32'(b_out_valid), 1);
      checkOutput($sformatf("bw_hold_pc_%0d", i), 32'(b_pc), 32'h27);
      checkOutput($sformatf("bw_hold_ready_%0d", i), 32'(b_in_ready), 0);
      checkOutput($sformatf("bw_hold_stall_%0d", i), 32'(b_stall), 1);
      checkOutput($sformatf("bw_hold_scnt_%0d", i), b_stall_cnt, PERF ? 3 : 0);
      checkOutput($sformatf("bw_hold_bcnt_%0d", i), b_bubble_cnt, PERF ? 4 : 0);
    end
    busywait = 0;
    #1;
    checkOutput("bw_sb_kept", 32'(b_stall), 1);
    tick(); #1;
    checkOutput("bw_bubble_1", 32'(b_out_valid), 0);
    checkOutput("bw_stall_1", 32'(b_stall), 1);
    tick(); #1;
    checkOutput("bw_bubble_2", 32'(b_out_valid), 0);
    checkOutput("bw_stall_2", 32'(b_stall), 0);
    checkOutput("bw_ready_2", 32'(b_in_ready), 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    checkOutput("bw_add_valid", 32'(b_out_valid), 1);
    checkOutput("bw_add_rd", 32'(b_rd), 13);
    checkOutput("cnt_stall_5", b_stall_cnt, PERF ? 5 : 0);
    checkOutput("cnt_bubble_6", b_bubble_cnt, PERF ? 6 : 0);

    // Mid-run reset clears everything without a clock edge.
    @(negedge clk);
    #1;
    rst = 1;
    #1;
    checkOutput("async_rst_b_valid", 32'(b_out_valid), 0);
    checkOutput("async_rst_b_rd", 32'(b_rd), 0);
    checkOutput("async_rst_b_scnt", b_stall_cnt, 0);
    checkOutput("async_rst_b_bcnt", b_bubble_cnt, 0);
    mon_en = 0;
    tick();
    rst = 0;
    tick();
    checkOutput("sb_queue_drained", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
